// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory-port arbiter.
package mem_arbiter_pkg;

  localparam int unsigned MA_ADDR_W = 32;
  localparam int unsigned MA_DATA_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_IFU,
    OWN_LSU
  } arb_owner_e;

  // Default-width request payload; the top builds a parameter-width
  // equivalent and hands it to the slots as a type parameter.
  typedef struct packed {
    logic [MA_ADDR_W-1:0]   addr;
    logic                   wen;
    logic [MA_DATA_W-1:0]   wdata;
    logic [MA_DATA_W/8-1:0] wmask;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_slot.sv
// One-deep pending request buffer with same-cycle bypass and overflow detect.
module arb_req_slot
  import mem_arbiter_pkg::*;
#(
  parameter type req_t = mem_req_t
) (
  input  logic clock,
  input  logic reset,
  input  logic req_valid,
  input  req_t req_data,
  input  logic clear,
  output logic slot_valid,
  output logic cand_valid,
  output req_t cand_data,
  output logic ovf
);

  req_t slot_data;

  // Hold a request until granted; a pulse granted via bypass is never stored.
  always_ff @(posedge clock) begin
    if (reset) begin
      slot_valid <= 1'b0;
      slot_data  <= '0;
    end else if (slot_valid) begin
      if (clear) slot_valid <= 1'b0;
    end else if (req_valid && !clear) begin
      slot_valid <= 1'b1;
      slot_data  <= req_data;
    end
  end

  // Candidate is the stored request, else the live pulse; a pulse into a full slot is dropped.
  always_comb begin
    cand_valid = slot_valid | req_valid;
    cand_data  = slot_valid ? slot_data : req_data;
    ovf        = req_valid & slot_valid;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the memory port between IFU and LSU with fixed LSU priority,
// one transaction in flight, response routing and a response watchdog.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                ifu_reqValid,
  input  logic [ADDR_W-1:0]   ifu_addr,
  output logic                ifu_respValid,
  output logic [DATA_W-1:0]   ifu_rdata,
  input  logic                lsu_reqValid,
  input  logic [ADDR_W-1:0]   lsu_addr,
  input  logic                lsu_wen,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wmask,
  output logic                lsu_respValid,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic                mem_reqValid,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_respValid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                resp_err,
  output logic                proto_ovf,
  output logic                busy
);

  localparam int unsigned MASK_W = DATA_W / 8;
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } req_t;

  arb_state_e       state, state_n;
  arb_owner_e       owner, owner_n;
  logic [CNT_W-1:0] wd_cnt;
  req_t             ifu_in, lsu_in, ifu_cand, lsu_cand, mem_q;
  logic             ifu_cand_valid, lsu_cand_valid;
  logic             ifu_slot_valid, lsu_slot_valid;
  logic             ifu_ovf, lsu_ovf;
  logic             grant_ifu, grant_lsu;
  logic             resp_ok, resp_to, wd_expired;

  // Pack requester inputs; the fetch path is always a full-width read.
  always_comb begin
    ifu_in       = '0;
    ifu_in.addr  = ifu_addr;
    lsu_in       = '0;
    lsu_in.addr  = lsu_addr;
    lsu_in.wen   = lsu_wen;
    lsu_in.wdata = lsu_wdata;
    lsu_in.wmask = lsu_wmask;
  end

  arb_req_slot #(.req_t(req_t)) u_ifu_slot (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (ifu_reqValid),
    .req_data   (ifu_in),
    .clear      (grant_ifu),
    .slot_valid (ifu_slot_valid),
    .cand_valid (ifu_cand_valid),
    .cand_data  (ifu_cand),
    .ovf        (ifu_ovf)
  );

  arb_req_slot #(.req_t(req_t)) u_lsu_slot (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (lsu_reqValid),
    .req_data   (lsu_in),
    .clear      (grant_lsu),
    .slot_valid (lsu_slot_valid),
    .cand_valid (lsu_cand_valid),
    .cand_data  (lsu_cand),
    .ovf        (lsu_ovf)
  );

  assign wd_expired = (TIMEOUT != 0) && (wd_cnt == CNT_LAST);

  // State and owner registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB_IDLE;
      owner <= OWN_IFU;
    end else begin
      state <= state_n;
      owner <= owner_n;
    end
  end

  // Next-state: grant in IDLE (LSU first), single issue cycle, wait for response or watchdog.
  always_comb begin
    state_n   = state;
    owner_n   = owner;
    grant_ifu = 1'b0;
    grant_lsu = 1'b0;
    resp_ok   = 1'b0;
    resp_to   = 1'b0;
    case (state)
      ARB_IDLE: begin
        if (lsu_cand_valid) begin
          grant_lsu = 1'b1;
          owner_n   = OWN_LSU;
          state_n   = ARB_ISSUE;
        end else if (ifu_cand_valid) begin
          grant_ifu = 1'b1;
          owner_n   = OWN_IFU;
          state_n   = ARB_ISSUE;
        end
      end
      ARB_ISSUE: state_n = ARB_WAIT;
      ARB_WAIT: begin
        if (mem_respValid) begin
          resp_ok = 1'b1;
          state_n = ARB_IDLE;
        end else if (wd_expired) begin
          resp_to = 1'b1;
          state_n = ARB_IDLE;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  // Watchdog: cleared on issue, counts WAIT cycles, saturates.
  always_ff @(posedge clock) begin
    if (reset) begin
      wd_cnt <= '0;
    end else if (state == ARB_ISSUE) begin
      wd_cnt <= '0;
    end else if (state == ARB_WAIT && wd_cnt != '1) begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end

  // Registered payload captured on grant.
  always_ff @(posedge clock) begin
    if (reset) begin
      mem_q <= '0;
    end else if (grant_lsu) begin
      mem_q <= lsu_cand;
    end else if (grant_ifu) begin
      mem_q <= ifu_cand;
    end
  end

  // Sticky protocol-overflow flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      proto_ovf <= 1'b0;
    end else if (ifu_ovf || lsu_ovf) begin
      proto_ovf <= 1'b1;
    end
  end

  // Response routing; a reset cycle suppresses any completion in flight.
  always_comb begin
    mem_reqValid  = (state == ARB_ISSUE);
    mem_addr      = mem_q.addr;
    mem_wen       = mem_q.wen;
    mem_wdata     = mem_q.wdata;
    mem_wmask     = mem_q.wmask;
    ifu_respValid = (resp_ok || resp_to) && !reset && (owner == OWN_IFU);
    lsu_respValid = (resp_ok || resp_to) && !reset && (owner == OWN_LSU);
    resp_err      = resp_to && !reset;
    ifu_rdata     = (ifu_respValid && resp_ok) ? mem_rdata : '0;
    lsu_rdata     = (lsu_respValid && resp_ok) ? mem_rdata : '0;
    busy          = (state != ARB_IDLE) || ifu_slot_valid || lsu_slot_valid;
  end

endmodule
